// File: rtl/block_memory_16kx1.sv
// block_memory_16kx1: 8192x16 single-port write-first block RAM with boot-constant power-up image
module block_memory_16kx1 #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 13
) (
   input  logic                  clka,
   input  logic                  rsta,
   input  logic                  wea,
   input  logic [ADDR_WIDTH-1:0] addra,
   input  logic [DATA_WIDTH-1:0] dina,
   output logic [DATA_WIDTH-1:0] douta
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{
      0:  DATA_WIDTH'('h0000),
      1:  DATA_WIDTH'('h0001),
      2:  DATA_WIDTH'('h0002),
      3:  DATA_WIDTH'('h0003),
      4:  DATA_WIDTH'('h0004),
      5:  DATA_WIDTH'('h0005),
      6:  DATA_WIDTH'('h0006),
      7:  DATA_WIDTH'('h0007),
      8:  DATA_WIDTH'('h0008),
      9:  DATA_WIDTH'('h0009),
      10: DATA_WIDTH'('h000A),
      11: DATA_WIDTH'('h000B),
      12: DATA_WIDTH'('h1000),
      13: DATA_WIDTH'('h2000),
      14: DATA_WIDTH'('h3000),
      15: DATA_WIDTH'('h4000),
      16: DATA_WIDTH'('h5000),
      17: DATA_WIDTH'('h6000),
      18: DATA_WIDTH'('h7000),
      19: DATA_WIDTH'('h8000),
      default: '0
   };
   logic [DATA_WIDTH-1:0] dout_q = '0;
   assign douta = dout_q;
   // array write port; reset never touches the contents, so a write under reset still lands
   always_ff @(posedge clka) begin
      if (wea) mem[addra] <= dina;
   end
   // registered read, write-first on a write edge, cleared by reset
   always_ff @(posedge clka) begin
      if (rsta) dout_q <= '0;
      else dout_q <= wea ? dina : mem[addra];
   end
endmodule

// File: tb/tb_block_memory_16kx1.sv
// tb_block_memory_16kx1: randomized and directed checks of block_memory_16kx1 against a behavioural model
module tb_block_memory_16kx1;
   logic        clk = 0;
   logic        rsta = 0;
   logic        wea = 0;
   logic [12:0] addra = '0;
   logic [15:0] dina = '0;
   logic [15:0] douta;
   int          asserts = 0;
   int          fails = 0;
   logic [15:0] model [8192];
   logic [15:0] exp_q = '0;
   logic [15:0] upper [8] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000,
                              16'h5000, 16'h6000, 16'h7000, 16'h8000};

   block_memory_16kx1 dut (
      .clka (clk),
      .rsta (rsta),
      .wea  (wea),
      .addra(addra),
      .dina (dina),
      .douta(douta)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 8192; i++)
         model[i] = i < 12 ? 16'(i) : i < 20 ? 16'((i - 11) * 4096) : 16'h0000;
   end

   // behavioural model: what the port must show after each edge
   always @(posedge clk) begin
      if (rsta) exp_q = 16'h0000;
      else if (wea) exp_q = dina;
      else exp_q = model[addra];
      if (wea) model[addra] = dina;
   end

   // compare process, sampled mid-cycle
   always @(negedge clk) begin
      asserts++;
      if (douta !== exp_q) begin
         fails++;
         $display("FAIL model t=%0t addr=%0d got=%h expected=%h", $time, addra, douta, exp_q);
      end
   end

   task automatic step(input logic we, input logic [12:0] a, input logic [15:0] d, input logic r);
      @(negedge clk);
      wea = we;
      addra = a;
      dina = d;
      rsta = r;
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [15:0] want);
      asserts++;
      if (douta !== want) begin
         fails++;
         $display("FAIL %s got=%h expected=%h", name, douta, want);
      end
   endtask

   initial begin
      #1;
      lit("power_up", 16'h0000);
      for (int a = 0; a < 12; a++) begin
         step(0, 13'(a), 16'h0, 0);
         lit("preload_low", 16'(a));
         step(0, 13'(a), 16'h0, 0);
         lit("preload_low_hold", 16'(a));
      end
      for (int a = 12; a < 20; a++) begin
         step(0, 13'(a), 16'h0, 0);
         lit("preload_high", upper[a - 12]);
      end
      step(0, 13'd20, 16'h0, 0);
      lit("addr20", 16'h0000);
      step(0, 13'd8191, 16'h0, 0);
      lit("addr8191", 16'h0000);
      step(1, 13'd100, 16'hBEEF, 0);
      lit("write_first", 16'hBEEF);
      step(0, 13'd99, 16'h0, 0);
      lit("read99", 16'h0000);
      step(0, 13'd100, 16'h0, 0);
      lit("read100", 16'hBEEF);
      step(1, 13'd3, 16'h1234, 0);
      lit("overwrite3", 16'h1234);
      step(0, 13'd3, 16'h0, 0);
      lit("read3", 16'h1234);
      step(0, 13'd4, 16'h0, 0);
      lit("read4", 16'h0004);
      step(0, 13'd19, 16'h0, 0);
      lit("read19", 16'h8000);
      step(0, 13'd19, 16'h0, 1);
      lit("reset_clear", 16'h0000);
      step(0, 13'd19, 16'h0, 0);
      lit("reset_retain", 16'h8000);
      step(1, 13'd200, 16'h00AA, 1);
      lit("reset_write", 16'h0000);
      step(0, 13'd201, 16'h0, 0);
      lit("read201", 16'h0000);
      step(0, 13'd200, 16'h0, 0);
      lit("read200", 16'h00AA);
      for (int n = 0; n < 3000; n++) begin
         logic [12:0] a;
         a = $urandom_range(0, 3) == 0 ? 13'($urandom) : 13'($urandom_range(0, 40));
         step($urandom_range(0, 9) < 3, a, 16'($urandom), $urandom_range(0, 19) == 0);
      end
      @(negedge clk);
      wea = 0;
      rsta = 0;
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule
